text_console_wb: RTL
====================

// Module: text_console_wb
// PURPOSE
//  Wishbone initiator that turns an incoming character stream (e.g. from UART RX) into writes
//  to the 80x30 text RAM read by the VGA controller. Tracks a cursor, handles CR/LF/BS and
//  auto-wrap. Scrolls the screen up by one line (read/write copy plus blank fill) when the cursor
//  moves past the last row. Drives the slave side of the text block RAM directly.
// PARAMETERS
//  COLS    80     characters per row
//  ROWS    30     rows on screen; COLS*ROWS <= 2**ADDR_W
//  ADDR_W  12     text RAM address width
//  BLANK   8'h20  fill character used for backspace erase and scroll clear
// PORTS
//  clk         in   1       system clock
//  rst         in   1       reset, asynchronous, active-high
//  i_valid     in   1       character available on i_char
//  i_char      in   8       character code
//  o_ready     out  1       block can take a character this cycle
//  o_wb_stb    out  1       bus request strobe
//  i_wb_stall  in   1       slave cannot accept request this cycle
//  i_wb_ack    in   1       slave completed the request
//  o_we        out  1       1 = write, 0 = read
//  o_addr      out  ADDR_W  RAM address = row*COLS + col
//  o_data      out  8       write data
//  i_data      in   8       read data, valid in the i_wb_ack cycle
//  o_cur_row   out  5       cursor row, 0..ROWS-1
//  o_cur_col   out  7       cursor column, 0..COLS-1
// BEHAVIOUR
//  Reset (async): state IDLE; o_wb_stb=0, o_we=0, o_addr=0, o_data=0, o_ready=0; cursor (0,0).
//   - o_ready=1 in the first cycle after rst deasserts.
//  o_ready=1 only in IDLE. A character is taken at the edge where i_valid && o_ready.
//  Bus rules: single outstanding request only.
//   - o_wb_stb rises the cycle after a request is decided.
//   - o_wb_stb, o_we, o_addr and o_data stay stable until an edge with o_wb_stb && !i_wb_stall.
//   - o_wb_stb drops the next cycle; the FSM then waits for i_wb_ack.
//   - Reads latch i_data on the ack edge. An ack while no request is in flight is ignored.
//  Character decode:
//   - 0x20..0x7E: write char at cursor, then col+1; if col==COLS-1 then col=0 and advance row.
//   - 0x0D CR: col=0, no bus access.
//   - 0x0A LF: col=0 and advance row; no bus access unless a scroll is needed.
//   - 0x08 BS: if col>0, col-1 and write BLANK at the new position; col==0: no-op.
//   - All other codes: accepted and discarded; o_ready returns the next cycle.
//  Advance row: if row<ROWS-1 then row+1; else row stays ROWS-1 and SCROLL runs.
//  FSM states: IDLE, WR, WR_ACK, SC_RD, SC_RD_ACK, SC_WR, SC_WR_ACK, CLR, CLR_ACK.
//   - Printable/BS: IDLE -> WR -> WR_ACK. In WR_ACK, on ack: update cursor, go to IDLE, or to
//     SC_RD if a wrap on the last row requires a scroll.
//   - Scroll: for a = COLS .. COLS*ROWS-1, read a (SC_RD/SC_RD_ACK) then write that data at
//     a-COLS (SC_WR/SC_WR_ACK).
//   - Clear: write BLANK to (ROWS-1)*COLS .. ROWS*COLS-1 (CLR/CLR_ACK), then IDLE.
//   - Cursor stays at (ROWS-1, 0) for the whole scroll.
//  Latency: zero stall and ack one cycle after stb gives char accept at edge T, stb high T+1..T+2,
//   ack at T+3, o_ready=1 from T+4.
//  Address arithmetic: row*COLS built from shifts and adds (80 = 64+16), no multiplier.
//   - The scroll index is a separate ADDR_W counter; the source address never exceeds
//     COLS*ROWS-1.
//  Reset mid-operation (including mid-scroll): o_wb_stb drops immediately, FSM returns to IDLE,
//   the partial scroll is abandoned, cursor returns to (0,0).
// TESTING
//  1. Reset, send 0x41 -> one write addr 0 data 0x41; cursor (0,1); o_ready high 4 cycles later.
//  2. Send 80 x 0x42 from (0,0) -> writes addr 0..79; cursor (1,0); no read issued.
//  3. Hold i_wb_stall 3 cycles on a write -> stb/addr/data constant; exactly one write accepted.
//  4. Cursor (2,5), send 0x08 -> write 0x20 at 164, cursor (2,4); at (2,0) 0x08 -> no bus cycle.
//  5. Cursor (29,0), memory model addr n = n[7:0], send 0x0A -> 2320 reads (80..2399), 2320
//     writes to a-80, then 80 writes of 0x20 at 2320..2399; final cursor (29,0); model matches.
//  6. Assert rst during scroll copy -> o_wb_stb low same cycle; after release cursor (0,0),
//     o_ready=1, and a stray ack is ignored.

Source files
------------

// File: rtl/text_console_wb.sv
// text_console_wb
//   Turns a character stream into Wishbone writes to an 80x30 text RAM.
//   Keeps a cursor and handles CR, LF, BS and auto-wrap. When the cursor
//   moves past the last row, the screen scrolls up one line: every cell
//   from row 1 onward is read and written back one row higher, and then
//   the last row is filled with BLANK.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   i_valid/i_char      incoming character, taken when i_valid && o_ready
//   o_ready             high only while idle
//   o_wb_stb/o_we       bus request strobe and direction (1 = write)
//   o_addr/o_data       request address (row*COLS + col) and write data
//   i_wb_stall/i_wb_ack slave flow control and completion
//   i_data              read data, sampled in the ack cycle
//   o_cur_row/o_cur_col cursor position
module text_console_wb #(
    parameter int         COLS   = 80,
    parameter int         ROWS   = 30,
    parameter int         ADDR_W = 12,
    parameter logic [7:0] BLANK  = 8'h20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [7:0]        i_char,
    output logic              o_ready,
    output logic              o_wb_stb,
    input  logic              i_wb_stall,
    input  logic              i_wb_ack,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_data,
    input  logic [7:0]        i_data,
    output logic [4:0]        o_cur_row,
    output logic [6:0]        o_cur_col
);

    // Each request state is immediately followed by its ack state, so
    // "request accepted" is simply state_q + 1.
    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] WR        = 4'd1;
    localparam logic [3:0] WR_ACK    = 4'd2;
    localparam logic [3:0] SC_RD     = 4'd3;
    localparam logic [3:0] SC_RD_ACK = 4'd4;
    localparam logic [3:0] SC_WR     = 4'd5;
    localparam logic [3:0] SC_WR_ACK = 4'd6;
    localparam logic [3:0] CLR       = 4'd7;
    localparam logic [3:0] CLR_ACK   = 4'd8;

    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);

    logic [3:0]        state_q, state_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              ready_q;
    logic [4:0]        row_q, row_d;
    logic [6:0]        col_q, col_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              bs_q, bs_d;

    // row*COLS as a chain of shifted adds, one stage per set bit of COLS.
    logic [ADDR_W-1:0] row_ext;
    logic [ADDR_W-1:0] pp [0:ADDR_W];
    logic [ADDR_W-1:0] cursor_addr;

    assign row_ext = ADDR_W'(row_q);
    assign pp[0]   = '0;

    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_row_mul
            assign pp[gi+1] = pp[gi] + (COLS_A[gi] ? (row_ext << gi) : '0);
        end
    endgenerate

    assign cursor_addr = pp[ADDR_W] + ADDR_W'(col_q);

    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        row_d   = row_q;
        col_d   = col_q;
        idx_d   = idx_q;
        bs_d    = bs_q;

        case (state_q)
            IDLE: begin
                if (i_valid && ready_q) begin
                    if (i_char >= 8'h20 && i_char <= 8'h7E) begin
                        addr_d  = cursor_addr;
                        data_d  = i_char;
                        we_d    = 1'b1;
                        bs_d    = 1'b0;
                        state_d = WR;
                    end else if (i_char == 8'h0D) begin
                        col_d = '0;
                    end else if (i_char == 8'h0A) begin
                        col_d = '0;
                        if (row_q < LAST_ROW) begin
                            row_d = row_q + 5'd1;
                        end else begin
                            idx_d   = COLS_A;
                            addr_d  = COLS_A;
                            we_d    = 1'b0;
                            state_d = SC_RD;
                        end
                    end else if (i_char == 8'h08) begin
                        if (col_q != '0) begin
                            addr_d  = cursor_addr - ADDR_W'(1);
                            data_d  = BLANK;
                            we_d    = 1'b1;
                            bs_d    = 1'b1;
                            state_d = WR;
                        end
                    end
                end
            end

            // Strobe rises one cycle after entry, then holds until accepted.
            WR, SC_RD, SC_WR, CLR: begin
                if (!stb_q) begin
                    stb_d = 1'b1;
                end else if (!i_wb_stall) begin
                    stb_d   = 1'b0;
                    state_d = state_q + 4'd1;
                end
            end

            WR_ACK: begin
                if (i_wb_ack) begin
                    state_d = IDLE;
                    if (bs_q) begin
                        col_d = col_q - 7'd1;
                    end else if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q < LAST_ROW) begin
                            row_d = row_q + 5'd1;
                        end else begin
                            idx_d   = COLS_A;
                            addr_d  = COLS_A;
                            we_d    = 1'b0;
                            state_d = SC_RD;
                        end
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end
            end

            SC_RD_ACK: begin
                if (i_wb_ack) begin
                    data_d  = i_data;
                    addr_d  = idx_q - COLS_A;
                    we_d    = 1'b1;
                    state_d = SC_WR;
                end
            end

            SC_WR_ACK: begin
                if (i_wb_ack) begin
                    if (idx_q == LAST_ADDR) begin
                        idx_d   = LAST_BASE;
                        addr_d  = LAST_BASE;
                        data_d  = BLANK;
                        we_d    = 1'b1;
                        state_d = CLR;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        addr_d  = idx_q + ADDR_W'(1);
                        we_d    = 1'b0;
                        state_d = SC_RD;
                    end
                end
            end

            CLR_ACK: begin
                if (i_wb_ack) begin
                    if (idx_q == LAST_ADDR) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        addr_d  = idx_q + ADDR_W'(1);
                        state_d = CLR;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            bs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            // Registered so that it is low throughout reset.
            ready_q <= (state_d == IDLE);
            row_q   <= row_d;
            col_q   <= col_d;
            idx_q   <= idx_d;
            bs_q    <= bs_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_wb_stb  = stb_q;
    assign o_we      = we_q;
    assign o_addr    = addr_q;
    assign o_data    = data_q;
    assign o_cur_row = row_q;
    assign o_cur_col = col_q;

endmodule
